alu_seq: RTL
============

Name: alu_seq

Overview:
- Initiator-side sequencer for the 32-bit combinational ALU.
- Accepts commands on a valid/ready interface and drives the ALU operand, op and carry-in ports.
- Captures the ALU result, carry, zero and negative outputs, and returns a registered response.
- Adds 64-bit ("wide") arithmetic/logic as two ALU passes with carry chaining, plus a persistent carry flag for adc/sbc chains.

Parameters:
- CARRY_INIT, 1'b0, reset value of flag_carry.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  8  ALU op code (0 add, 1 adc, 2 sub, 3 sbc, 4 or, 5 and, 6 not, 7 xor, 8 cmp, 12 shl, 13 shr)
- cmd_wide  in  1  64-bit operation request
- cmd_a  in  64  operand A (narrow ops use [31:0])
- cmd_b  in  64  operand B (narrow ops use [31:0])
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_op  out  8  to ALU op
- alu_carry_in  out  1  to ALU carry_in
- alu_c  in  32  from ALU c
- alu_carry_out  in  1  from ALU carry_out
- alu_is_zero  in  1  from ALU is_zero
- alu_is_negative  in  1  from ALU is_negative
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_c  out  64  result; [63:32]=0 for narrow
- rsp_carry  out  1  carry/borrow of the last pass
- rsp_zero  out  1  whole result is zero
- rsp_neg  out  1  sign bit of the result
- flag_carry  out  1  persistent carry flag

Behaviour:
- Reset (async, active-high), effective immediately:
  - state=IDLE, rsp_valid=0, rsp_c=0, rsp_carry=0, rsp_zero=0, rsp_neg=0, flag_carry=CARRY_INIT.
  - Internal operand/low-pass registers cleared.
  - An in-flight command is dropped with no response.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On cmd_valid&cmd_ready, latch op/wide/a/b and go to LO.
- LO:
  - alu_a=a[31:0], alu_b=b[31:0], alu_op=op.
  - alu_carry_in = flag_carry if op is 1 or 3, else 0.
  - At the clock edge, capture lo_c, lo_carry, lo_zero, lo_neg.
  - Next state: HI if wide and op<=7, else DONE.
- HI:
  - alu_a=a[63:32], alu_b=b[63:32].
  - alu_op = 1 if op=0; 3 if op=2; otherwise op.
  - alu_carry_in = lo_carry for ops 0-3, else 0.
  - At the clock edge, go to DONE.
- Wide requests with op>7 run narrow (LO only). rsp_c[63:32]=0 in that case.
- Registered on entry to DONE:
  - Narrow: rsp_c={32'b0,lo_c}, rsp_carry=lo_carry, rsp_zero=lo_zero, rsp_neg=lo_neg.
  - Wide: rsp_c={alu_c,lo_c}, rsp_carry=alu_carry_out, rsp_zero=lo_zero&alu_is_zero, rsp_neg=alu_is_negative.
  - flag_carry<=rsp_carry's new value, for every op (cmp and shifts included).
- DONE:
  - rsp_valid=1; rsp_* and flag_carry held stable while rsp_ready=0.
  - On rsp_ready, go to IDLE; rsp_valid deasserts next cycle.
  - rsp_c and flags keep their value until the next DONE entry.
- Outside LO/HI: alu_a=0, alu_b=0, alu_op=0, alu_carry_in=0.
- Latency, counted from the accept edge:
  - rsp_valid high after 2 edges for narrow, 3 edges for wide.
  - Minimum command spacing is 3 cycles (narrow) or 4 cycles (wide), with rsp_ready held high.
- No combinational path from cmd_* to rsp_* or from rsp_ready to cmd_ready.
- Undefined ops (9-11, 14-255): ALU returns 0, so the response is rsp_c=0, carry=0, zero=1, neg=0, and flag_carry is cleared.
- cmd_* changes while cmd_ready=0 are ignored.
- No overflow flag is produced.

Test Plan:
- Narrow add: a=0xFFFFFFFF, b=1 -> rsp_c=0, carry=1, zero=1, neg=0; rsp_valid 2 edges after accept; flag_carry=1.
- Wide add: a=0x00000000_FFFFFFFF, b=1 -> rsp_c=0x00000001_00000000, carry=0, zero=0. ALU observes op 0 then op 1, with alu_carry_in=1 on the HI pass.
- Wide sub: a=0, b=1 -> rsp_c=0xFFFFFFFF_FFFFFFFF, carry=1, neg=1, zero=0. ALU observes op 2 then 3.
- Carry chain: narrow add 0xFFFFFFFF+1 (flag_carry=1), then narrow adc 2+3 -> rsp_c=6, flag_carry=0. Then wide op 12 on 0x1_80000000 -> runs narrow, rsp_c=0x00000000_00000000, carry=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0, a concurrent cmd_valid is not accepted. After rsp_ready, cmd_ready=1 one cycle later and the pending command is accepted.
- Reset mid-op: assert reset while in HI of a wide add -> immediately state=IDLE, rsp_valid=0, flag_carry=CARRY_INIT, alu_op=0. After release, a narrow xor 0xF0F0F0F0^0xFFFFFFFF -> 0x0F0F0F0F.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: initiator-side sequencer for a 32-bit combinational ALU.
// Accepts commands on a valid/ready interface, drives the ALU for one
// (narrow) or two (wide, carry-chained) passes, and returns a registered
// response together with a persistent carry flag for adc/sbc chains.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op/cmd_wide/cmd_a/cmd_b     command payload (narrow ops use [31:0])
//   alu_a/alu_b/alu_op/alu_carry_in operands and op driven to the ALU
//   alu_c/alu_carry_out/
//   alu_is_zero/alu_is_negative     ALU results
//   rsp_valid/rsp_ready             response handshake
//   rsp_c/rsp_carry/rsp_zero/rsp_neg response payload
//   flag_carry                      persistent carry flag
module alu_seq #(
   parameter logic CARRY_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_op,
   input  logic        cmd_wide,
   input  logic [63:0] cmd_a,
   input  logic [63:0] cmd_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [7:0]  alu_op,
   output logic        alu_carry_in,
   input  logic [31:0] alu_c,
   input  logic        alu_carry_out,
   input  logic        alu_is_zero,
   input  logic        alu_is_negative,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_c,
   output logic        rsp_carry,
   output logic        rsp_zero,
   output logic        rsp_neg,
   output logic        flag_carry
);

   localparam int unsigned DW = 64;
   localparam int unsigned HW = 32;
   localparam int unsigned OW = 8;

   localparam logic [OW-1:0] OP_ADD = OW'(0);
   localparam logic [OW-1:0] OP_ADC = OW'(1);
   localparam logic [OW-1:0] OP_SUB = OW'(2);
   localparam logic [OW-1:0] OP_SBC = OW'(3);
   localparam logic [OW-1:0] OP_XOR = OW'(7);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   op_q, op_d;
   logic            wide_q, wide_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [HW-1:0]   lo_c_q, lo_c_d;
   logic            lo_carry_q, lo_carry_d;
   logic            lo_zero_q, lo_zero_d;
   logic            lo_neg_q, lo_neg_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic [HW-1:0]   alu_a_q, alu_a_d;
   logic [HW-1:0]   alu_b_q, alu_b_d;
   logic [OW-1:0]   alu_op_q, alu_op_d;
   logic            alu_carry_in_q, alu_carry_in_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_c_q, rsp_c_d;
   logic            rsp_carry_q, rsp_carry_d;
   logic            rsp_zero_q, rsp_zero_d;
   logic            rsp_neg_q, rsp_neg_d;
   logic            flag_carry_q, flag_carry_d;

   // Next-state and output computation; ALU drive is registered one edge
   // ahead of the pass it belongs to, so it is computed from the state we enter.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      wide_d         = wide_q;
      a_d            = a_q;
      b_d            = b_q;
      lo_c_d         = lo_c_q;
      lo_carry_d     = lo_carry_q;
      lo_zero_d      = lo_zero_q;
      lo_neg_d       = lo_neg_q;
      alu_a_d        = '0;
      alu_b_d        = '0;
      alu_op_d       = '0;
      alu_carry_in_d = 1'b0;
      rsp_valid_d    = rsp_valid_q;
      rsp_c_d        = rsp_c_q;
      rsp_carry_d    = rsp_carry_q;
      rsp_zero_d     = rsp_zero_q;
      rsp_neg_d      = rsp_neg_q;
      flag_carry_d   = flag_carry_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d           = cmd_op;
               wide_d         = cmd_wide;
               a_d            = cmd_a;
               b_d            = cmd_b;
               state_d        = LO;
               alu_a_d        = cmd_a[HW-1:0];
               alu_b_d        = cmd_b[HW-1:0];
               alu_op_d       = cmd_op;
               alu_carry_in_d = (cmd_op == OP_ADC || cmd_op == OP_SBC) ? flag_carry_q : 1'b0;
            end
         end
         LO: begin
            lo_c_d     = alu_c;
            lo_carry_d = alu_carry_out;
            lo_zero_d  = alu_is_zero;
            lo_neg_d   = alu_is_negative;
            if (wide_q && op_q <= OP_XOR) begin
               state_d  = HI;
               alu_a_d  = a_q[DW-1:HW];
               alu_b_d  = b_q[DW-1:HW];
               // Upper pass of add/sub chains the low-pass carry/borrow
               if (op_q == OP_ADD)      alu_op_d = OP_ADC;
               else if (op_q == OP_SUB) alu_op_d = OP_SBC;
               else                     alu_op_d = op_q;
               alu_carry_in_d = (op_q <= OP_SBC) ? alu_carry_out : 1'b0;
            end else begin
               state_d      = DONE;
               rsp_valid_d  = 1'b1;
               rsp_c_d      = {HW'(0), alu_c};
               rsp_carry_d  = alu_carry_out;
               rsp_zero_d   = alu_is_zero;
               rsp_neg_d    = alu_is_negative;
               flag_carry_d = alu_carry_out;
            end
         end
         HI: begin
            state_d      = DONE;
            rsp_valid_d  = 1'b1;
            rsp_c_d      = {alu_c, lo_c_q};
            rsp_carry_d  = alu_carry_out;
            rsp_zero_d   = lo_zero_q & alu_is_zero;
            rsp_neg_d    = alu_is_negative;
            flag_carry_d = alu_carry_out;
         end
         DONE: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      cmd_ready_d = (state_d == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         op_q           <= '0;
         wide_q         <= 1'b0;
         a_q            <= '0;
         b_q            <= '0;
         lo_c_q         <= '0;
         lo_carry_q     <= 1'b0;
         lo_zero_q      <= 1'b0;
         lo_neg_q       <= 1'b0;
         cmd_ready_q    <= 1'b1;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_op_q       <= '0;
         alu_carry_in_q <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_c_q        <= '0;
         rsp_carry_q    <= 1'b0;
         rsp_zero_q     <= 1'b0;
         rsp_neg_q      <= 1'b0;
         flag_carry_q   <= CARRY_INIT;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         wide_q         <= wide_d;
         a_q            <= a_d;
         b_q            <= b_d;
         lo_c_q         <= lo_c_d;
         lo_carry_q     <= lo_carry_d;
         lo_zero_q      <= lo_zero_d;
         lo_neg_q       <= lo_neg_d;
         cmd_ready_q    <= cmd_ready_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_op_q       <= alu_op_d;
         alu_carry_in_q <= alu_carry_in_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_c_q        <= rsp_c_d;
         rsp_carry_q    <= rsp_carry_d;
         rsp_zero_q     <= rsp_zero_d;
         rsp_neg_q      <= rsp_neg_d;
         flag_carry_q   <= flag_carry_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign alu_carry_in = alu_carry_in_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_c        = rsp_c_q;
   assign rsp_carry    = rsp_carry_q;
   assign rsp_zero     = rsp_zero_q;
   assign rsp_neg      = rsp_neg_q;
   assign flag_carry   = flag_carry_q;

endmodule
